// File: rtl/roce_stack_pkg.sv
// Shared types for the RoCE request path: translation response, error codes, FSM states
// and the datamover command layout with its packing helper.
package roce_stack_pkg;

    localparam int unsigned CMD_W        = 104;
    localparam int unsigned CMD_BTT_W    = 23;
    localparam int unsigned CMD_TAG_W    = 4;
    localparam int unsigned CMD_ADDR_W   = 64;
    localparam int unsigned CMD_BTT_LSB  = 0;
    localparam int unsigned CMD_INCR_BIT = 23;
    localparam int unsigned CMD_EOF_BIT  = 30;
    localparam int unsigned CMD_ADDR_LSB = 32;
    localparam int unsigned CMD_TAG_LSB  = 96;

    typedef struct packed {
        logic [63:0] paddr;
        logic [47:0] buflen;
        logic [3:0]  accesdesc;
    } dma_req_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ZERO_LEN = 2'd1,
        ERR_OVERRUN  = 2'd2,
        ERR_ACCESS   = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XREQ,
        ST_XRESP,
        ST_CHECK,
        ST_EMIT,
        ST_ERR
    } state_e;

    // DRR and DSA stay zero; INCR is always set.
    function automatic logic [CMD_W-1:0] pack_dm_cmd(
        input logic [CMD_TAG_W-1:0]  tag,
        input logic [CMD_ADDR_W-1:0] addr,
        input logic                  eof,
        input logic [CMD_BTT_W-1:0]  btt
    );
        logic [CMD_W-1:0] cmd;
        cmd                            = '0;
        cmd[CMD_BTT_LSB +: CMD_BTT_W]  = btt;
        cmd[CMD_INCR_BIT]              = 1'b1;
        cmd[CMD_EOF_BIT]               = eof;
        cmd[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
        cmd[CMD_TAG_LSB +: CMD_TAG_W]  = tag;
        return cmd;
    endfunction

endpackage

// File: rtl/roce_req_cmd_gen.sv
// RDMA request to datamover command generator; translates the opening request of a message.
// Define ROCE_REQ_CMD_GEN_STATS_EN to add saturating command/byte/error counters.
module roce_req_cmd_gen
    import roce_stack_pkg::*;
#(
    parameter bit          READ       = 1'b1,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned LEN_W      = 28,
    parameter int unsigned BTT_W      = 23,
    parameter int unsigned CHUNK_LOG2 = 22
) (
    input  logic              clk_i,
    input  logic              areset_i,
    input  logic              s_rdma_req_valid_i,
    output logic              s_rdma_req_ready_o,
    input  logic [ADDR_W-1:0] s_rdma_req_vaddr_i,
    input  logic [LEN_W-1:0]  s_rdma_req_len_i,
    input  logic [15:0]       s_rdma_req_qpn_i,
    input  logic              s_rdma_req_last_i,
    output logic              req_addr_valid_o,
    input  logic              req_addr_ready_i,
    output logic [ADDR_W-1:0] req_addr_vaddr_o,
    output logic [15:0]       req_addr_qpn_o,
    input  logic              resp_addr_valid_i,
    output logic              resp_addr_ready_o,
    input  dma_req_t          resp_addr_data_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [CMD_W-1:0]  cmd_data_o,
    output logic              err_valid_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       err_qpn_o,
    output logic              busy_o
`ifdef ROCE_REQ_CMD_GEN_STATS_EN
    ,
    output logic [31:0]       stat_cmds_o,
    output logic [47:0]       stat_bytes_o,
    output logic [15:0]       stat_errs_o
`endif
);

    localparam int unsigned PADDR_W  = 64;
    localparam int unsigned BUFLEN_W = 48;
    localparam logic [LEN_W-1:0] CHUNK_LEN = LEN_W'(64'd1 << CHUNK_LOG2);

    function automatic logic [BTT_W-1:0] chunk_of(input logic [LEN_W-1:0] left);
        return (left > CHUNK_LEN) ? BTT_W'(CHUNK_LEN) : BTT_W'(left);
    endfunction

    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  last_q, last_d;
    logic                  opener_q, opener_d;
    logic [PADDR_W-1:0]    paddr_q, paddr_d;
    logic [BUFLEN_W-1:0]   rem_q, rem_d;
    logic                  acc_ok_q, acc_ok_d;
    logic [CMD_TAG_W-1:0]  tag_q, tag_d;
    logic                  first_q, first_d;
    logic [ADDR_W-1:0]     vaddr_d;
    logic [15:0]           qpn_d, err_qpn_d;
    err_code_e             err_code_d;
    logic [CMD_W-1:0]      cmd_data_d;
    logic [BTT_W-1:0]      chunk;
    logic                  unused_acc;

    assign chunk      = chunk_of(len_q);
    assign unused_acc = &{1'b0, resp_addr_data_i.accesdesc[3:2]};

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        last_d     = last_q;
        opener_d   = opener_q;
        paddr_d    = paddr_q;
        rem_d      = rem_q;
        acc_ok_d   = acc_ok_q;
        tag_d      = tag_q;
        first_d    = first_q;
        vaddr_d    = req_addr_vaddr_o;
        qpn_d      = req_addr_qpn_o;
        err_code_d = err_code_e'(err_code_o);
        err_qpn_d  = err_qpn_o;
        cmd_data_d = cmd_data_o;

        unique case (state_q)
            ST_IDLE: begin
                if (s_rdma_req_valid_i && s_rdma_req_ready_o) begin
                    vaddr_d  = s_rdma_req_vaddr_i;
                    len_d    = s_rdma_req_len_i;
                    qpn_d    = s_rdma_req_qpn_i;
                    last_d   = s_rdma_req_last_i;
                    opener_d = first_q;
                    state_d  = first_q ? ST_XREQ : ST_CHECK;
                end
            end
            ST_XREQ: begin
                if (req_addr_ready_i) state_d = ST_XRESP;
            end
            ST_XRESP: begin
                if (resp_addr_valid_i) begin
                    paddr_d  = resp_addr_data_i.paddr;
                    rem_d    = resp_addr_data_i.buflen;
                    acc_ok_d = READ ? resp_addr_data_i.accesdesc[0] : resp_addr_data_i.accesdesc[1];
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_d = ST_EMIT;
                if (len_q == '0) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_ZERO_LEN;
                end else if (opener_q && !acc_ok_q) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_ACCESS;
                end else if (BUFLEN_W'(len_q) > rem_q) begin
                    state_d    = ST_ERR;
                    err_code_d = ERR_OVERRUN;
                end
                if (state_d == ST_ERR) err_qpn_d = req_addr_qpn_o;
            end
            ST_EMIT: begin
                if (cmd_ready_i) begin
                    paddr_d = paddr_q + PADDR_W'(chunk);
                    rem_d   = rem_q - BUFLEN_W'(chunk);
                    len_d   = len_q - LEN_W'(chunk);
                    tag_d   = tag_q + CMD_TAG_W'(1);
                    if (len_q <= CHUNK_LEN) begin
                        state_d = ST_IDLE;
                        first_d = last_q;
                    end
                end
            end
            ST_ERR: begin
                first_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Holds while stalled because the next values equal the current ones.
        if (state_d == ST_EMIT) begin
            cmd_data_d = pack_dm_cmd(tag_d, paddr_d, len_d <= CHUNK_LEN,
                                     CMD_BTT_W'(chunk_of(len_d)));
        end
    end

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            state_q            <= ST_IDLE;
            len_q              <= '0;
            last_q             <= 1'b0;
            opener_q           <= 1'b0;
            paddr_q            <= '0;
            rem_q              <= '0;
            acc_ok_q           <= 1'b0;
            tag_q              <= '0;
            first_q            <= 1'b1;
            req_addr_vaddr_o   <= '0;
            req_addr_qpn_o     <= '0;
            s_rdma_req_ready_o <= 1'b0;
            req_addr_valid_o   <= 1'b0;
            resp_addr_ready_o  <= 1'b0;
            cmd_valid_o        <= 1'b0;
            cmd_data_o         <= '0;
            err_valid_o        <= 1'b0;
            err_code_o         <= '0;
            err_qpn_o          <= '0;
            busy_o             <= 1'b0;
        end else begin
            state_q            <= state_d;
            len_q              <= len_d;
            last_q             <= last_d;
            opener_q           <= opener_d;
            paddr_q            <= paddr_d;
            rem_q              <= rem_d;
            acc_ok_q           <= acc_ok_d;
            tag_q              <= tag_d;
            first_q            <= first_d;
            req_addr_vaddr_o   <= vaddr_d;
            req_addr_qpn_o     <= qpn_d;
            s_rdma_req_ready_o <= (state_d == ST_IDLE);
            req_addr_valid_o   <= (state_d == ST_XREQ);
            resp_addr_ready_o  <= (state_d == ST_XRESP);
            cmd_valid_o        <= (state_d == ST_EMIT);
            cmd_data_o         <= cmd_data_d;
            err_valid_o        <= (state_d == ST_ERR);
            err_code_o         <= err_code_d;
            err_qpn_o          <= err_qpn_d;
            busy_o             <= (state_d != ST_IDLE);
        end
    end

`ifdef ROCE_REQ_CMD_GEN_STATS_EN
    logic [BUFLEN_W:0] bytes_sum;

    assign bytes_sum = {1'b0, stat_bytes_o} + (BUFLEN_W + 1)'(chunk);

    // Saturating activity counters.
    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            stat_cmds_o  <= '0;
            stat_bytes_o <= '0;
            stat_errs_o  <= '0;
        end else begin
            if (cmd_valid_o && cmd_ready_i) begin
                if (stat_cmds_o != '1) stat_cmds_o <= stat_cmds_o + 32'd1;
                stat_bytes_o <= bytes_sum[BUFLEN_W] ? '1 : bytes_sum[BUFLEN_W-1:0];
            end
            if (err_valid_o && stat_errs_o != '1) stat_errs_o <= stat_errs_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_roce_req_cmd_gen.sv
// Randomised bench for roce_req_cmd_gen against a message-level reference model.
module tb_roce_req_cmd_gen;
    import roce_stack_pkg::*;

    localparam int unsigned CHUNK = 1 << 22;

    logic              clk_i = 1'b0;
    logic              areset_i;
    logic              s_rdma_req_valid_i;
    logic              s_rdma_req_ready_o;
    logic [63:0]       s_rdma_req_vaddr_i;
    logic [27:0]       s_rdma_req_len_i;
    logic [15:0]       s_rdma_req_qpn_i;
    logic              s_rdma_req_last_i;
    logic              req_addr_valid_o;
    logic              req_addr_ready_i;
    logic [63:0]       req_addr_vaddr_o;
    logic [15:0]       req_addr_qpn_o;
    logic              resp_addr_valid_i;
    logic              resp_addr_ready_o;
    dma_req_t          resp_addr_data_i;
    logic              cmd_valid_o;
    logic              cmd_ready_i;
    logic [103:0]      cmd_data_o;
    logic              err_valid_o;
    logic [1:0]        err_code_o;
    logic [15:0]       err_qpn_o;
    logic              busy_o;
`ifdef ROCE_REQ_CMD_GEN_STATS_EN
    logic [31:0]       stat_cmds_o;
    logic [47:0]       stat_bytes_o;
    logic [15:0]       stat_errs_o;
`endif

    always #5 clk_i = ~clk_i;

    roce_req_cmd_gen dut (
        .clk_i              (clk_i),
        .areset_i           (areset_i),
        .s_rdma_req_valid_i (s_rdma_req_valid_i),
        .s_rdma_req_ready_o (s_rdma_req_ready_o),
        .s_rdma_req_vaddr_i (s_rdma_req_vaddr_i),
        .s_rdma_req_len_i   (s_rdma_req_len_i),
        .s_rdma_req_qpn_i   (s_rdma_req_qpn_i),
        .s_rdma_req_last_i  (s_rdma_req_last_i),
        .req_addr_valid_o   (req_addr_valid_o),
        .req_addr_ready_i   (req_addr_ready_i),
        .req_addr_vaddr_o   (req_addr_vaddr_o),
        .req_addr_qpn_o     (req_addr_qpn_o),
        .resp_addr_valid_i  (resp_addr_valid_i),
        .resp_addr_ready_o  (resp_addr_ready_o),
        .resp_addr_data_i   (resp_addr_data_i),
        .cmd_valid_o        (cmd_valid_o),
        .cmd_ready_i        (cmd_ready_i),
        .cmd_data_o         (cmd_data_o),
        .err_valid_o        (err_valid_o),
        .err_code_o         (err_code_o),
        .err_qpn_o          (err_qpn_o),
        .busy_o             (busy_o)
`ifdef ROCE_REQ_CMD_GEN_STATS_EN
        ,
        .stat_cmds_o        (stat_cmds_o),
        .stat_bytes_o       (stat_bytes_o),
        .stat_errs_o        (stat_errs_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state: message-level view of translation and progress.
    bit          m_first = 1'b1;
    logic [63:0] m_paddr = '0;
    logic [47:0] m_rem   = '0;
    logic [3:0]  m_acc   = '0;
    logic [3:0]  m_tag   = '0;

    task automatic run_req(input logic [63:0] vaddr, input logic [27:0] len, input logic [15:0] qpn,
                           input bit last, input logic [63:0] paddr, input logic [47:0] buflen,
                           input logic [3:0] acc, input int stall, input bit fast, input bit rst_in_emit);
        logic [103:0] exp_q[$];
        bit           exp_x;
        int           exp_err;
        logic [27:0]  r;
        logic [22:0]  c;
        logic         eof;
        int           n, got, nx, nerr, first_cyc, stall_left;
        bit           done;

        exp_x = m_first;
        if (m_first) begin
            m_paddr = paddr;
            m_rem   = buflen;
            m_acc   = acc;
        end
        exp_err = 0;
        if (len == 0)                    exp_err = 1;
        else if (exp_x && !m_acc[0])     exp_err = 3;
        else if (48'(len) > m_rem)       exp_err = 2;
        if (exp_err != 0) begin
            m_first = 1'b1;
        end else begin
            r = len;
            while (r != 0) begin
                c   = (r > 28'(CHUNK)) ? 23'(CHUNK) : 23'(r);
                eof = (r == 28'(c));
                exp_q.push_back({4'b0, m_tag, m_paddr, 1'b0, eof, 6'b0, 1'b1, c});
                m_paddr = m_paddr + 64'(c);
                m_rem   = m_rem - 48'(c);
                m_tag   = m_tag + 4'd1;
                r       = r - 28'(c);
            end
            m_first = last;
        end

        @(negedge clk_i);
        s_rdma_req_valid_i = 1'b1;
        s_rdma_req_vaddr_i = vaddr;
        s_rdma_req_len_i   = len;
        s_rdma_req_qpn_i   = qpn;
        s_rdma_req_last_i  = last;
        resp_addr_data_i   = {paddr, buflen, acc};
        n = 0;
        while (!s_rdma_req_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (!s_rdma_req_ready_o) begin
            check_eq("accept_timeout", 128'(0), 128'(1));
            s_rdma_req_valid_i = 1'b0;
            return;
        end
        @(negedge clk_i);
        s_rdma_req_valid_i = 1'b0;

        got = 0; nx = 0; nerr = 0; first_cyc = 0; stall_left = stall; done = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
            if (cyc > 1) @(negedge clk_i);
            req_addr_ready_i  = 1'b0;
            resp_addr_valid_i = 1'b0;
            cmd_ready_i       = 1'b0;
            if (!busy_o) begin
                done = 1'b1;
            end else begin
                if (req_addr_valid_o && (fast || $urandom_range(0, 2) == 0)) begin
                    req_addr_ready_i = 1'b1;
                    nx++;
                    check_eq("xreq_vaddr", 128'(req_addr_vaddr_o), 128'(vaddr));
                    check_eq("xreq_qpn", 128'(req_addr_qpn_o), 128'(qpn));
                end
                if (resp_addr_ready_o) resp_addr_valid_i = fast || ($urandom_range(0, 2) == 0);
                if (cmd_valid_o) begin
                    if (first_cyc == 0) first_cyc = cyc;
                    if (got < exp_q.size()) check_eq("cmd_data", 128'(cmd_data_o), 128'(exp_q[got]));
                    else                    check_eq("cmd_extra", 128'(cmd_valid_o), 128'(0));
                    if (rst_in_emit && got >= 1) begin
                        #1 areset_i = 1'b1;
                        #1;
                        check_eq("rst_cmd_valid", 128'(cmd_valid_o), 128'(0));
                        check_eq("rst_cmd_data", 128'(cmd_data_o), 128'(0));
                        check_eq("rst_busy", 128'(busy_o), 128'(0));
                        check_eq("rst_req_ready", 128'(s_rdma_req_ready_o), 128'(0));
                        @(negedge clk_i);
                        areset_i = 1'b0;
                        m_tag    = '0;
                        m_first  = 1'b1;
                        return;
                    end
                    if (stall_left > 0) stall_left--;
                    else if (fast || $urandom_range(0, 3) != 0) begin
                        cmd_ready_i = 1'b1;
                        got++;
                    end
                end
                if (err_valid_o) begin
                    nerr++;
                    check_eq("err_code", 128'(err_code_o), 128'(exp_err));
                    check_eq("err_qpn", 128'(err_qpn_o), 128'(qpn));
                end
            end
        end
        if (!done) check_eq("req_timeout", 128'(0), 128'(1));
        check_eq("n_cmds", 128'(got), 128'(exp_q.size()));
        check_eq("n_xlate", 128'(nx), 128'(exp_x));
        check_eq("n_err", 128'(nerr), 128'(exp_err != 0));
        if (exp_err == 0 && !exp_x)    check_eq("lat_cont", 128'(first_cyc), 128'(2));
        else if (exp_err == 0 && fast) check_eq("lat_xlate", 128'(first_cyc), 128'(4));
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [27:0] len;
        logic [47:0] buflen;
        logic [3:0]  acc;
        int          sel;

        areset_i           = 1'b1;
        s_rdma_req_valid_i = 1'b0;
        s_rdma_req_vaddr_i = '0;
        s_rdma_req_len_i   = '0;
        s_rdma_req_qpn_i   = '0;
        s_rdma_req_last_i  = 1'b0;
        req_addr_ready_i   = 1'b0;
        resp_addr_valid_i  = 1'b0;
        resp_addr_data_i   = '0;
        cmd_ready_i        = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("rst_ready", 128'(s_rdma_req_ready_o), 128'(0));
        check_eq("rst_xreq_valid", 128'(req_addr_valid_o), 128'(0));
        check_eq("rst_resp_ready", 128'(resp_addr_ready_o), 128'(0));
        check_eq("rst_cmd_valid", 128'(cmd_valid_o), 128'(0));
        check_eq("rst_cmd_data", 128'(cmd_data_o), 128'(0));
        check_eq("rst_err", 128'({err_valid_o, err_code_o, err_qpn_o}), 128'(0));
        check_eq("rst_busy", 128'(busy_o), 128'(0));
        areset_i = 1'b0;

        // Directed cases from the plan.
        run_req(64'h1000, 28'd256, 16'h0011, 1'b1, 64'h8000_0000, 48'd4096, 4'b0001, 0, 1'b1, 1'b0);
        run_req(64'h2000, 28'd100, 16'h0022, 1'b0, 64'h9000_0000, 48'd4096, 4'b0001, 0, 1'b1, 1'b0);
        run_req(64'h2064, 28'd200, 16'h0022, 1'b0, 64'h1111_0000, 48'd4096, 4'b0001, 0, 1'b0, 1'b0);
        run_req(64'h212C, 28'd300, 16'h0022, 1'b1, 64'h2222_0000, 48'd4096, 4'b0001, 0, 1'b0, 1'b0);
        run_req(64'h3000, 28'h0A0_0000, 16'h0033, 1'b1, 64'hA000_0000, 48'h100_0000, 4'b0001, 10, 1'b0, 1'b0);
        run_req(64'h4000, 28'd256, 16'h0044, 1'b1, 64'hB000_0000, 48'd128, 4'b0001, 0, 1'b0, 1'b0);
        run_req(64'h5000, 28'd64, 16'h0055, 1'b1, 64'hC000_0000, 48'd128, 4'b0001, 0, 1'b1, 1'b0);
        run_req(64'h6000, 28'd64, 16'h0066, 1'b1, 64'hD000_0000, 48'd4096, 4'b0010, 0, 1'b0, 1'b0);
        run_req(64'h7000, 28'd0, 16'h0077, 1'b1, 64'hE000_0000, 48'd4096, 4'b0001, 0, 1'b0, 1'b0);
        run_req(64'h8000, 28'h0A0_0000, 16'h0088, 1'b0, 64'hF000_0000, 48'h100_0000, 4'b0001, 0, 1'b1, 1'b1);
        run_req(64'h9000, 28'd512, 16'h0099, 1'b1, 64'h1234_5000, 48'd4096, 4'b0001, 0, 1'b1, 1'b0);
        run_req(64'hA000, 28'd32, 16'h00AA, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 48'd4096, 4'b0001, 0, 1'b0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 19);
            if (sel == 0)      len = '0;
            else if (sel == 1) len = 28'($urandom_range(32'h3F_FFFF, 32'h90_0000));
            else               len = 28'($urandom_range(1, 3000));
            buflen = ($urandom_range(0, 5) == 0) ? 48'($urandom_range(0, 4000))
                                                 : 48'($urandom_range(32'h100_0000, 32'h200_0000));
            acc    = ($urandom_range(0, 7) == 0) ? 4'b0010 : (4'($urandom) | 4'b0001);
            run_req({$urandom, $urandom}, len, 16'($urandom), $urandom_range(0, 2) == 0,
                    {$urandom, $urandom}, buflen, acc,
                    ($urandom_range(0, 5) == 0) ? 3 : 0, $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/roce_req_cmd_gen.md
Name: roce_req_cmd_gen

Overview:
Parametrised successor of the RoCE request handler. Accepts RDMA read/write requests and translates the first request of each message through the address-translation interface. Checks length and access rights against the returned buffer descriptor. Splits each request into one or more datamover commands of at most CHUNK_BYTES, tracking the physical address across the requests of a multi-request message. Sits between the RoCE stack request stream and the AXI datamover command port.

Parameters:
READ, 1'b1, 1 = read path (checks accessdesc[0]); 0 = write path (checks accessdesc[1])
ADDR_W, 64, virtual/physical address width (≤64; zero-extended into command)
LEN_W, 28, request length width
BTT_W, 23, datamover bytes-to-transfer field width (fixed command layout requires 23)
CHUNK_LOG2, 22, log2 of maximum bytes per command; must be < BTT_W

Ports:
clk_i  in  1  clock
areset_i  in  1  asynchronous active-high reset
s_rdma_req_valid_i  in  1  request valid
s_rdma_req_ready_o  out  1  request ready
s_rdma_req_vaddr_i  in  ADDR_W  virtual address (used only on first request of message)
s_rdma_req_len_i  in  LEN_W  bytes
s_rdma_req_qpn_i  in  16  queue pair
s_rdma_req_last_i  in  1  last request of message
req_addr_valid_o  out  1  translation request valid
req_addr_ready_i  in  1  translation request ready
req_addr_vaddr_o  out  ADDR_W  vaddr to translate
req_addr_qpn_o  out  16  qpn to translate
resp_addr_valid_i  in  1  translation response valid
resp_addr_ready_o  out  1  translation response ready
resp_addr_data_i  in  dma_req_t  {paddr[63:0], buflen[47:0], accesdesc[3:0]}
cmd_valid_o  out  1  datamover command valid
cmd_ready_i  in  1  datamover command ready
cmd_data_o  out  104  datamover command
err_valid_o  out  1  one-cycle error pulse
err_code_o  out  2  1 = zero length, 2 = overrun, 3 = access denied
err_qpn_o  out  16  qpn of failed request
busy_o  out  1  state != IDLE

Behaviour:
- Reset: all valid/ready outputs 0, err_code_o 0, err_qpn_o 0, cmd_data_o 0, busy_o 0, tag 0, first_q 1, paddr/remaining buflen 0, state IDLE.
- States: IDLE, XREQ, XRESP, CHECK, EMIT, ERR.
- IDLE: s_rdma_req_ready_o = 1. On accept, latch vaddr, len, qpn, and first_d = last_i.
  - first_q = 1 → XREQ.
  - first_q = 0 → CHECK, using running paddr_q and rem_q.
- XREQ: req_addr_valid_o = 1; vaddr/qpn held stable until req_addr_ready_i; then XRESP.
- XRESP: resp_addr_ready_o = 1. On valid, load paddr_q = paddr, rem_q = buflen, acc_q = accesdesc; then CHECK. resp_addr_ready_o is 0 in every other state.
- CHECK (1 cycle), priority order:
  - len == 0 → code 1.
  - Access bit clear → code 3; this check applies only when the request opened a message.
  - len > rem_q → code 2.
  - Any error → ERR; otherwise → EMIT.
- EMIT: present one command per chunk.
  - chunk = min(remaining request bytes, 2^CHUNK_LOG2).
  - cmd_data_o = {4'b0, tag[3:0], paddr (zero-extended to 64), 1'b0 DRR, EOF, 6'b0 DSA, 1'b1 INCR, chunk[22:0]}. EOF = 1 only on the final chunk of the request.
  - cmd_valid_o is registered; cmd_data_o is stable while valid && !ready.
  - On handshake: paddr_q += chunk (64-bit wrap, no check); rem_q -= chunk; tag += 1 (mod 16).
  - After the final chunk → IDLE, commit first_q = first_d.
- ERR: err_valid_o = 1 for exactly one cycle with code and qpn; set first_q = 1 so the next request re-translates; → IDLE. No command is issued for the failed request.
- Latency, single-chunk request with translation: accept → first cmd_valid_o after 4 cycles (XREQ, XRESP minimum, CHECK, EMIT). Continuation request: 2 cycles.
- A request is never accepted while a previous one is in flight; there is no overlap of handshakes.
- Reset asserted mid-operation: immediate return to reset values. Any pending cmd/translation valid drops; the datamover and translator must tolerate a dropped valid on reset.

Optional Feature:
ROCE_REQ_CMD_GEN_STATS_EN
- Defined: adds outputs stat_cmds_o[31:0] (command handshakes), stat_bytes_o[47:0] (sum of issued chunk lengths) and stat_errs_o[15:0] (error pulses). All three saturate at their maximum and reset to 0.
- Undefined: these ports and their counters do not exist.

Decomposition:
- Package roce_stack_pkg holds:
  - dma_req_t.
  - Error code enum err_code_e {ERR_NONE, ERR_ZERO_LEN, ERR_OVERRUN, ERR_ACCESS}.
  - Command field widths/offsets: CMD_W = 104, BTT field 23, tag 4.
  - Function pack_dm_cmd(tag, addr, eof, btt).
- No sub-module is natural: chunking is an in-FSM counter; the stats counters are inline under the macro.

Test Plan:
- Single request vaddr 0x1000, len 256, last 1; translation returns paddr 0x8000_0000, buflen 4096, accesdesc 4'b0001 → one command: addr 0x8000_0000, BTT 256, EOF 1, tag 0.
- Three-request message (len 100, 200, 300; last on third) → exactly one translation; commands at paddr P, P+100, P+300; tags 0, 1, 2.
- len 0x00A0_0000 with CHUNK_LOG2 22 → three commands: 0x40_0000, 0x40_0000, 0x20_0000; EOF only on the third; addresses advance by 0x40_0000.
- buflen 128, len 256 → err_valid_o one cycle with code 2 and the request's qpn; no cmd_valid_o; next request triggers a new translation.
- READ=1, accesdesc 4'b0010 → code 3. len 0 → code 1.
- cmd_ready_i held low for 10 cycles → cmd_data_o stable, valid held. Assert areset_i during EMIT → all valids 0 the same cycle, tag 0, next request re-translates.
